// File: rtl/mem_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// mem_op_sequencer_if
//   Bundles the control-sequencer <-> datapath/memory signals.
//   master : the sequencer (consumes start/ir_op/mem_ready, drives controls)
//   slave  : the datapath/memory side (the reverse directions)
//   Signals:
//     start, ir_op[4:0], mem_ready            -> sequencer inputs
//     pc_out, zlo_out, mdr_out, c_out          bus drivers
//     pc_in, mar_in, mdr_in, ir_in, y_in,
//     z_in, inc_pc                             register enables / PC increment
//     gra, grb, rin, rout, ba_out              select-and-encode controls
//     read, write                              memory strobes
//     alu_sel[ALU_W-1:0]                       ALU operation
//     busy, done, err, t_state[3:0]            status
// ----------------------------------------------------------------------------
interface mem_op_sequencer_if #(
  parameter int unsigned ALU_W = 6
);
  logic             start;
  logic [4:0]       ir_op;
  logic             mem_ready;
  logic             pc_out, zlo_out, mdr_out, c_out;
  logic             pc_in, mar_in, mdr_in, ir_in, y_in, z_in, inc_pc;
  logic             gra, grb, rin, rout, ba_out;
  logic             read, write;
  logic [ALU_W-1:0] alu_sel;
  logic             busy, done, err;
  logic [3:0]       t_state;

  modport master (
    input  start, ir_op, mem_ready,
    output pc_out, zlo_out, mdr_out, c_out,
    output pc_in, mar_in, mdr_in, ir_in, y_in, z_in, inc_pc,
    output gra, grb, rin, rout, ba_out,
    output read, write, alu_sel, busy, done, err, t_state
  );

  modport slave (
    output start, ir_op, mem_ready,
    input  pc_out, zlo_out, mdr_out, c_out,
    input  pc_in, mar_in, mdr_in, ir_in, y_in, z_in, inc_pc,
    input  gra, grb, rin, rout, ba_out,
    input  read, write, alu_sel, busy, done, err, t_state
  );
endinterface

// File: rtl/mem_op_sequencer.sv
// ----------------------------------------------------------------------------
// mem_op_sequencer
//   Control sequencer for the memory-class instructions ld, ldi and st.
//   Walks fetch (T0..T2) and execute (T3..T7) T-states; each T-state lasts at
//   least STEP_CYCLES clocks, and memory T-states additionally wait for
//   mem_ready, falling into ERR after STEP_CYCLES+WAIT_MAX clocks without it.
//   Ports:
//     clock : system clock, rising edge
//     clr   : asynchronous reset, active low
//     bus   : mem_op_sequencer_if.master (handshake inputs, datapath controls)
//   Every control/status output is a flop holding the decode of the state
//   register, so outputs follow a state change by one clock and stay constant
//   for the whole T-state.
// ----------------------------------------------------------------------------
module mem_op_sequencer #(
  parameter int unsigned      STEP_CYCLES = 4,
  parameter int unsigned      ALU_W       = 6,
  parameter logic [ALU_W-1:0] ALU_ADD     = {ALU_W{1'b0}},
  parameter int unsigned      WAIT_MAX    = 15,
  parameter logic [4:0]       OP_LD       = 5'b00000,
  parameter logic [4:0]       OP_LDI      = 5'b00001,
  parameter logic [4:0]       OP_ST       = 5'b00010
) (
  input logic              clock,
  input logic              clr,
  mem_op_sequencer_if.master bus
);

  localparam int unsigned LIMIT = STEP_CYCLES + WAIT_MAX;
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LIMIT - 1);

  typedef enum logic [3:0] {
    S_T0   = 4'd0,  S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4   = 4'd4,  S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_DONE = 4'd8,  S_ERR = 4'd9, S_IDLE = 4'd15
  } state_e;

  typedef struct packed {
    logic             pc_out, zlo_out, mdr_out, c_out;
    logic             pc_in, mar_in, mdr_in, ir_in, y_in, z_in, inc_pc;
    logic             gra, grb, rin, rout, ba_out;
    logic             read, write;
    logic [ALU_W-1:0] alu_sel;
    logic             busy, done, err;
    logic [3:0]       t_state;
  } ctrl_t;

  state_e           state_q, state_d, step_next;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             mem_state, advance, timeout, op_ok;

  // Step qualifiers: dwell expiry, memory handshake and wait timeout.
  always_comb begin
    mem_state = 1'b0;
    case (state_q)
      S_T1:    mem_state = 1'b1;
      S_T6:    mem_state = (op_q == OP_LD);
      S_T7:    mem_state = (op_q == OP_ST);
      default: mem_state = 1'b0;
    endcase
    advance = (cnt_q >= STEP_LAST) && (!mem_state || bus.mem_ready);
    timeout = mem_state && !bus.mem_ready && (cnt_q == WAIT_LAST);
    op_ok   = (bus.ir_op == OP_LD) || (bus.ir_op == OP_LDI) || (bus.ir_op == OP_ST);
  end

  // Next-state, opcode capture and dwell counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    step_next = S_IDLE;
    case (state_q)
      S_T0:    step_next = S_T1;
      S_T1:    step_next = S_T2;
      S_T2:    step_next = op_ok ? S_T3 : S_ERR;   // decode uses IR as latched
      S_T3:    step_next = S_T4;
      S_T4:    step_next = S_T5;
      S_T5:    step_next = (op_q == OP_LDI) ? S_DONE : S_T6;
      S_T6:    step_next = S_T7;
      S_T7:    step_next = S_DONE;
      default: step_next = S_IDLE;
    endcase

    case (state_q)
      S_IDLE: state_d = bus.start ? S_T0 : S_IDLE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = bus.start ? S_T0 : S_ERR;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (timeout) begin
          state_d = S_ERR;
        end else if (advance) begin
          state_d = step_next;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_T2) && advance) begin
      op_d = bus.ir_op;
    end else begin
      op_d = op_q;
    end

    // Counter restarts on every state entry; it only runs inside T-states.
    if ((state_d != state_q) || (state_q > S_T7)) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control decode for the current state (registered below).
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.t_state = state_q;
    ctrl_d.busy    = (state_q <= S_T7);
    case (state_q)
      S_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
      end
      S_T1: begin
        ctrl_d.read   = 1'b1;
        ctrl_d.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        ctrl_d.grb    = 1'b1;
        ctrl_d.ba_out = 1'b1;
        ctrl_d.y_in   = 1'b1;
      end
      S_T4: begin
        ctrl_d.c_out   = 1'b1;
        ctrl_d.z_in    = 1'b1;
        ctrl_d.alu_sel = ALU_ADD;
      end
      S_T5: begin
        ctrl_d.zlo_out = 1'b1;
        if (op_q == OP_LDI) begin
          ctrl_d.gra = 1'b1;
          ctrl_d.rin = 1'b1;
        end else begin
          ctrl_d.mar_in = 1'b1;
        end
      end
      S_T6: begin
        ctrl_d.mdr_in = 1'b1;
        if (op_q == OP_ST) begin
          ctrl_d.gra  = 1'b1;
          ctrl_d.rout = 1'b1;
        end else begin
          ctrl_d.read = 1'b1;
        end
      end
      S_T7: begin
        if (op_q == OP_ST) begin
          ctrl_d.write = 1'b1;
        end else begin
          ctrl_d.mdr_out = 1'b1;
          ctrl_d.gra     = 1'b1;
          ctrl_d.rin     = 1'b1;
        end
      end
      S_DONE:  ctrl_d.done = 1'b1;
      S_ERR:   ctrl_d.err  = 1'b1;
      default: ctrl_d.busy = 1'b0;
    endcase
  end

  // State, opcode, counter and output registers.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q        <= S_IDLE;
      op_q           <= 5'b00000;
      cnt_q          <= {CNT_W{1'b0}};
      ctrl_q         <= '0;
      ctrl_q.t_state <= S_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.pc_out  = ctrl_q.pc_out;
  assign bus.zlo_out = ctrl_q.zlo_out;
  assign bus.mdr_out = ctrl_q.mdr_out;
  assign bus.c_out   = ctrl_q.c_out;
  assign bus.pc_in   = ctrl_q.pc_in;
  assign bus.mar_in  = ctrl_q.mar_in;
  assign bus.mdr_in  = ctrl_q.mdr_in;
  assign bus.ir_in   = ctrl_q.ir_in;
  assign bus.y_in    = ctrl_q.y_in;
  assign bus.z_in    = ctrl_q.z_in;
  assign bus.inc_pc  = ctrl_q.inc_pc;
  assign bus.gra     = ctrl_q.gra;
  assign bus.grb     = ctrl_q.grb;
  assign bus.rin     = ctrl_q.rin;
  assign bus.rout    = ctrl_q.rout;
  assign bus.ba_out  = ctrl_q.ba_out;
  assign bus.read    = ctrl_q.read;
  assign bus.write   = ctrl_q.write;
  assign bus.alu_sel = ctrl_q.alu_sel;
  assign bus.busy    = ctrl_q.busy;
  assign bus.done    = ctrl_q.done;
  assign bus.err     = ctrl_q.err;
  assign bus.t_state = ctrl_q.t_state;

endmodule
